// File: rtl/isqrt_seq_if.sv
`default_nettype none
// ============================================================================
//  Module      : isqrt_seq_if
//  Description : Handshake bundle between a square-root requester (master)
//                and the isqrt_seq engine (slave).
//                  ce   - clock enable for the engine
//                  ld   - start pulse, radicand a sampled with it
//                  a    - WID-bit unsigned radicand
//                  o    - root, zero-extended to WID bits
//                  rem  - remainder a - root^2, WID/2+1 bits
//                  done - result valid (level)
//  Revision    : 1.0  initial release
// ============================================================================
interface isqrt_seq_if #(
  parameter int WID = 128
);
  logic           ce;
  logic           ld;
  logic [WID-1:0] a;
  logic [WID-1:0] o;
  logic [WID/2:0] rem;
  logic           done;

  modport master (output ce, ld, a, input o, rem, done);
  modport slave  (input ce, ld, a, output o, rem, done);
endinterface
`default_nettype wire

// File: rtl/isqrt_seq.sv
`default_nettype none
// ============================================================================
//  Module      : isqrt_seq
//  Description : Iterative radix-2 integer square root. Produces
//                floor(sqrt(a)) and a - root^2, one root bit per enabled
//                clock, WID/2 enabled clocks after ld is captured.
//  Ports       : clk  - clock, rising edge
//                rst  - asynchronous reset, active low
//                bus  - isqrt_seq_if slave (ce, ld, a -> o, rem, done)
//  Revision    : 1.0  initial release
// ============================================================================
module isqrt_seq #(
  parameter int WID = 128
) (
  input  logic        clk,
  input  logic        rst,
  isqrt_seq_if.slave  bus
);

  localparam int RW = WID / 2;
  localparam int CW = $clog2(RW) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [WID-1:0]  rad_q,   rad_d;
  logic [RW-1:0]   q_q,     q_d;
  logic [RW+1:0]   r_q,     r_d;
  logic [CW-1:0]   cnt_q,   cnt_d;
  logic [WID-1:0]  o_q,     o_d;
  logic [RW:0]     rem_q,   rem_d;
  logic            done_q,  done_d;

  // One trial-subtraction step: bring down the next radicand bit pair and
  // try to subtract 4*q+1. The extra top bit of w_diff is the borrow.
  logic [RW+2:0]   w_diff;
  logic            w_borrow;
  logic [RW-1:0]   w_q_next;
  logic [RW+1:0]   w_r_next;

  assign w_diff   = {1'b0, r_q[RW-1:0], rad_q[WID-1:WID-2]} - {1'b0, q_q, 2'b01};
  assign w_borrow = w_diff[RW+2];
  assign w_q_next = {q_q[RW-2:0], ~w_borrow};
  assign w_r_next = w_borrow ? {r_q[RW-1:0], rad_q[WID-1:WID-2]} : w_diff[RW+1:0];

  // The partial remainder never exceeds 2*q, so its two top bits are never
  // needed as shift input; they exist only to hold the full trial result.
  logic unused_r_hi;
  assign unused_r_hi = ^r_q[RW+1:RW];

  always_comb begin
    state_d = state_q;
    rad_d   = rad_q;
    q_d     = q_q;
    r_d     = r_q;
    cnt_d   = cnt_q;
    o_d     = o_q;
    rem_d   = rem_q;
    done_d  = done_q;

    if (bus.ce) begin
      if (bus.ld) begin
        // Start (or abort and restart) regardless of the current state.
        rad_d   = bus.a;
        q_d     = '0;
        r_d     = '0;
        cnt_d   = CW'(RW);
        done_d  = 1'b0;
        state_d = CALC;
      end else if (state_q == CALC) begin
        q_d   = w_q_next;
        r_d   = w_r_next;
        rad_d = {rad_q[WID-3:0], 2'b00};
        cnt_d = cnt_q - {{(CW-1){1'b0}}, 1'b1};
        if (cnt_q == {{(CW-1){1'b0}}, 1'b1}) begin
          o_d     = {{(WID-RW){1'b0}}, w_q_next};
          rem_d   = w_r_next[RW:0];
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      rad_q   <= '0;
      q_q     <= '0;
      r_q     <= '0;
      cnt_q   <= '0;
      o_q     <= '0;
      rem_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rad_q   <= rad_d;
      q_q     <= q_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
      o_q     <= o_d;
      rem_q   <= rem_d;
      done_q  <= done_d;
    end
  end

  assign bus.o    = o_q;
  assign bus.rem  = rem_q;
  assign bus.done = done_q;

endmodule
`default_nettype wire

// File: doc/isqrt_seq.md
# isqrt_seq

Iterative radix-2 integer square-root engine: the responder on the `ld`/`done` handshake that the floating-point square-root wrapper initiates. It accepts a WID-bit unsigned radicand, produces floor(sqrt(a)) and the remainder one result bit per enabled clock, and signals completion on `done`. It sits under the FP sqrt front end and is reusable by any block needing an exact integer root.

## Interface
- WID, 128, radicand width in bits; even, >= 4. Root width is WID/2.
- clk  input  1  sole clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-low reset.
- ce  input  1  clock enable; when low, all state holds, including across `ld`.
- ld  input  1  start pulse; sampled on rising edge with ce=1.
- a  input  WID  unsigned radicand; sampled only on the `ld` edge.
- o  output  WID  root, zero-extended: o[WID/2-1:0]=floor(sqrt(a)), o[WID-1:WID/2]=0.
- rem  output  WID/2+1  a - root^2 (max 2·root, fits).
- done  output  1  result valid; level signal.

## Operation
- States: IDLE, CALC, DONE.
- Registers: rad (WID, radicand shift register), q (WID/2, partial root), r (WID/2+2, partial remainder), cnt (clog2(WID/2)+1).
- Reset (rst=0, asynchronous): state=IDLE, o=0, rem=0, done=0, rad=q=r=cnt=0.
- Any state, ce=1, ld=1: rad<=a, q<=0, r<=0, cnt<=WID/2, done<=0, state<=CALC. `ld` in CALC aborts and restarts; the old result is lost.
- CALC, ce=1, ld=0, per edge:
  - t = {r[WID/2-1:0], rad[WID-1:WID-2]} - {q, 2'b01}, computed at WID/2+2 bits plus borrow.
  - If no borrow: r<=t, q<={q[WID/2-2:0],1}; else r<={r[WID/2-1:0],rad[WID-1:WID-2]}, q<={q[WID/2-2:0],0}.
  - rad<=rad<<2; cnt<=cnt-1.
  - When cnt==1 on this edge, also o<={0,next q}, rem<=next r[WID/2:0], done<=1, state<=DONE.
- DONE: o, rem and done=1 hold until the next `ld` or reset.
- IDLE: o, rem, done hold their reset values; no iteration.
- o and rem update only on the final CALC edge. They never show partial values, and they stay at their previous values while a calculation is in flight.

## Timing
- `ld` sampled on edge k. Iterations on edges k+1..k+WID/2. done=1, o and rem valid after edge k+WID/2. Latency is WID/2 enabled cycles (64 for WID=128).
- done falls after edge k, i.e. the cycle after `ld` is captured.
- ce=0 cycles stretch latency 1:1. No iteration and no `ld` capture occur while ce=0.
- `ld` on the final CALC edge has priority: it restarts, and o/rem/done do not update.
- `ld` held high for several cycles restarts each edge. The computation proceeds only after `ld` is released.
- Reset mid-CALC: immediate return to IDLE with all outputs 0. No result is produced.
- Back-to-back: `ld` in the cycle done is first high starts a new op. done drops on that edge.

## Test plan
- WID=8, rst released, ld with a=144 -> after exactly 4 enabled edges done=1, o=12, rem=0. done=0 for the 3 intermediate cycles.
- WID=8, exhaustive a=0..255 -> o=floor(sqrt(a)), rem=a-o². Includes a=0 -> o=0,rem=0 and a=255 -> o=15,rem=30.
- WID=128:
  - a=2^126 -> o=2^63, rem=0 after 64 cycles.
  - a=2^128-1 -> o=2^64-1, rem=2^65-2.
- WID=8, a=200 with ce toggling 0/1 each cycle -> done after 8 clocks (4 enabled), o=14, rem=4. Outputs stay stable during ce=0.
- WID=8:
  - ld a=255, then ld a=49 two cycles later -> done 4 edges after the second ld, o=7, rem=0. No intermediate done pulse.
  - Separately, assert rst mid-CALC -> o=0, rem=0, done=0 immediately (asynchronous), state IDLE.
